// File: rtl/kairo_div_pkg.sv
// kairo_div_pkg: shared types and constants for the kairo iterative divider.
// Contents: FSM state enum, op-kind enum, special-result constants, iteration count.
package kairo_div_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OP_DIV, OP_DIVU, OP_REM, OP_REMU} op_t;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam int ITER = 32;
endpackage

// File: rtl/kairo_div_core.sv
// kairo_div_core: unsigned 32-step restoring divide stepper, one quotient bit per step.
// Ports: CLK, RST_N (async active-low); start loads dvd_in/dsr_in and count=ITER-1;
// step runs one iteration; last flags the final step; quo_nxt/rem_nxt are the post-step values.
module kairo_div_core
  import kairo_div_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dvd_in,
  input  logic [31:0] dsr_in,
  output logic        last,
  output logic [31:0] quo_nxt,
  output logic [31:0] rem_nxt
);
  logic [31:0] dvd, dsr, rem, quo;
  logic [4:0]  count;
  logic [32:0] rem_sh, diff;
  logic        ge;
  // A 33-bit shifted remainder is always below 2*divisor, so the borrow bit alone decides the quotient bit.
  always_comb begin
    rem_sh  = {rem, dvd[31]};
    diff    = rem_sh - {1'b0, dsr};
    ge      = ~diff[32];
    rem_nxt = ge ? diff[31:0] : rem_sh[31:0];
    quo_nxt = {quo[30:0], ge};
  end
  assign last = count == 5'd0;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dvd   <= '0;
      dsr   <= '0;
      rem   <= '0;
      quo   <= '0;
      count <= '0;
    end else if (start) begin
      dvd   <= dvd_in;
      dsr   <= dsr_in;
      rem   <= '0;
      quo   <= '0;
      count <= 5'(ITER - 1);
    end else if (step) begin
      dvd   <= dvd << 1;
      rem   <= rem_nxt;
      quo   <= quo_nxt;
      count <= count - 5'd1;
    end
  end
endmodule

// File: rtl/kairo_div.sv
// kairo_div: iterative RV32M divider (DIV/DIVU/REM/REMU) with WAIT/READY stall handshake.
// Ports: CLK, RST_N (async active-low); INST_* one-hot op strobes; RS1 dividend, RS2 divisor;
// WAIT stall request; READY one-cycle result pulse; RD result (zero unless READY).
module kairo_div
  import kairo_div_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        INST_DIV,
  input  logic        INST_DIVU,
  input  logic        INST_REM,
  input  logic        INST_REMU,
  input  logic [31:0] RS1,
  input  logic [31:0] RS2,
  output logic        WAIT,
  output logic        READY,
  output logic [31:0] RD
);
  state_t      state, state_nxt;
  op_t         op;
  logic        inst_div, sgn, is_rem, special, start, step, last;
  logic        qneg, rneg, rem_sel;
  logic [31:0] res, special_res, dvd_abs, dsr_abs, quo_nxt, rem_nxt;
  assign inst_div = INST_DIV | INST_DIVU | INST_REM | INST_REMU;
  always_comb begin
    op          = INST_DIV ? OP_DIV : INST_DIVU ? OP_DIVU : INST_REM ? OP_REM : OP_REMU;
    sgn         = op == OP_DIV || op == OP_REM;
    is_rem      = op == OP_REM || op == OP_REMU;
    dvd_abs     = (sgn && RS1[31]) ? -RS1 : RS1;
    dsr_abs     = (sgn && RS2[31]) ? -RS2 : RS2;
    special     = RS2 == '0 || (sgn && RS1 == INT_MIN && RS2 == 32'hFFFF_FFFF);
    special_res = RS2 == '0 ? (is_rem ? RS1 : DIV_ZERO_Q) : (is_rem ? '0 : INT_MIN);
  end
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    step      = 1'b0;
    start     = state == IDLE && inst_div && !special;
    step      = state == BUSY && inst_div;
    state_nxt = state == IDLE ? (inst_div ? (special ? DONE : BUSY) : IDLE) :
                state == BUSY ? (!inst_div ? IDLE : last ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      rem_sel <= 1'b0;
      res     <= '0;
    end else begin
      if (state == IDLE && inst_div) begin
        qneg    <= sgn & (RS1[31] ^ RS2[31]);
        rneg    <= sgn & RS1[31];
        rem_sel <= is_rem;
        res     <= special_res;
      end
      if (step && last) res <= rem_sel ? (rneg ? -rem_nxt : rem_nxt) : (qneg ? -quo_nxt : quo_nxt);
    end
  end
  kairo_div_core u_core (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .start  (start),
    .step   (step),
    .dvd_in (dvd_abs),
    .dsr_in (dsr_abs),
    .last   (last),
    .quo_nxt(quo_nxt),
    .rem_nxt(rem_nxt)
  );
  assign READY = state == DONE;
  assign RD    = READY ? res : '0;
  // Gated by RST_N so a held strobe cannot raise WAIT while reset is asserted.
  assign WAIT  = RST_N & inst_div & ~READY;
endmodule

// File: tb/tb_kairo_div.sv
// tb_kairo_div: self-checking bench for kairo_div (directed table, corner sequences, random vs model).
module tb_kairo_div;
  import kairo_div_pkg::*;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        INST_DIV = 1'b0, INST_DIVU = 1'b0, INST_REM = 1'b0, INST_REMU = 1'b0;
  logic [31:0] RS1 = '0, RS2 = '0;
  logic        WAIT, READY;
  logic [31:0] RD;
  int n_cmp = 0, n_bad = 0;
  always #5 CLK = ~CLK;
  kairo_div dut (
    .CLK(CLK), .RST_N(RST_N),
    .INST_DIV(INST_DIV), .INST_DIVU(INST_DIVU), .INST_REM(INST_REM), .INST_REMU(INST_REMU),
    .RS1(RS1), .RS2(RS2), .WAIT(WAIT), .READY(READY), .RD(RD)
  );
  typedef struct {
    op_t         op;
    logic [31:0] a, b, exp;
    int          lat;
    string       nm;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] model(input op_t op, input logic [31:0] a, input logic [31:0] b);
    logic r, s;
    logic [31:0] q;
    r = op == OP_REM || op == OP_REMU;
    s = op == OP_DIV || op == OP_REM;
    if (b == 0) return r ? a : 32'hFFFF_FFFF;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
    if (s && r) q = $signed(a) % $signed(b);
    else if (s) q = $signed(a) / $signed(b);
    else if (r) q = a % b;
    else q = a / b;
    return q;
  endfunction
  function automatic int model_lat(input op_t op, input logic [31:0] a, input logic [31:0] b);
    logic s;
    s = op == OP_DIV || op == OP_REM;
    return (b == 0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
  endfunction
  task automatic set_op(input op_t op, input logic en);
    INST_DIV  = en && op == OP_DIV;
    INST_DIVU = en && op == OP_DIVU;
    INST_REM  = en && op == OP_REM;
    INST_REMU = en && op == OP_REMU;
  endtask
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask
  // Issues at the current cycle start, waits for READY (bounded), checks, ends at the start of the following cycle.
  task automatic do_op(input op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string nm);
    int   cyc;
    logic wait_ok;
    cyc = 0;
    wait_ok = 1'b1;
    set_op(op, 1'b1);
    RS1 = a;
    RS2 = b;
    @(negedge CLK);
    while (!READY && cyc < 60) begin
      if (!WAIT) wait_ok = 1'b0;
      cyc++;
      next_cycle();
      RS1 = $urandom;
      RS2 = $urandom;
      @(negedge CLK);
    end
    chk({nm, " latency"}, 32'(cyc), 32'(lat));
    chk({nm, " rd"}, RD, exp);
    chk({nm, " wait_busy"}, {31'd0, wait_ok}, 32'd1);
    chk({nm, " wait_done"}, {31'd0, WAIT}, 32'd0);
    next_cycle();
  endtask
  initial begin
    vecs.push_back('{OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7"});
    vecs.push_back('{OP_REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7"});
    vecs.push_back('{OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2"});
    vecs.push_back('{OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2"});
    vecs.push_back('{OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2"});
    vecs.push_back('{OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2"});
    vecs.push_back('{OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_dz"});
    vecs.push_back('{OP_REMU, 32'd5, 32'd0, 32'd5, 1, "remu_dz"});
    vecs.push_back('{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf"});
    vecs.push_back('{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf"});
    vecs.push_back('{OP_DIV, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1, "div_dz"});
    vecs.push_back('{OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, "rem_dz"});
    vecs.push_back('{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu_big"});
    vecs.push_back('{OP_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 33, "div_min_1"});
    vecs.push_back('{OP_DIVU, 32'd10, 32'd3, 32'd3, 33, "b2b_divu"});
    vecs.push_back('{OP_REMU, 32'd10, 32'd3, 32'd1, 33, "b2b_remu"});
    #3;
    chk("reset wait", {31'd0, WAIT}, 32'd0);
    chk("reset ready", {31'd0, READY}, 32'd0);
    chk("reset rd", RD, 32'd0);
    next_cycle();
    RST_N = 1'b1;
    next_cycle();
    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].nm);
    set_op(OP_DIV, 1'b0);
    next_cycle();
    set_op(OP_DIVU, 1'b1);
    RS1 = 32'd100;
    RS2 = 32'd7;
    repeat (10) next_cycle();
    set_op(OP_DIVU, 1'b0);
    @(negedge CLK);
    chk("abort ready c10", {31'd0, READY}, 32'd0);
    next_cycle();
    @(negedge CLK);
    chk("abort idle c11", 32'(dut.state), 32'(IDLE));
    chk("abort ready c11", {31'd0, READY}, 32'd0);
    next_cycle();
    do_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "after_abort");
    set_op(OP_DIVU, 1'b1);
    RS1 = 32'd100;
    RS2 = 32'd7;
    repeat (5) next_cycle();
    #2;
    RST_N = 1'b0;
    #1;
    chk("async rst wait", {31'd0, WAIT}, 32'd0);
    chk("async rst ready", {31'd0, READY}, 32'd0);
    chk("async rst rd", RD, 32'd0);
    chk("async rst state", 32'(dut.state), 32'(IDLE));
    next_cycle();
    RST_N = 1'b1;
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "after_rst");
    for (int k = 0; k < 40; k++) begin
      op_t         op;
      logic [31:0] a, b;
      int          r;
      op = op_t'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0) b = '0;
      else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (r == 2) b = $urandom_range(1, 15);
      else if (r == 3) b = -$urandom_range(1, 15);
      do_op(op, a, b, model(op, a, b), model_lat(op, a, b), $sformatf("rand%0d", k));
      if ($urandom_range(0, 1) == 1) begin
        set_op(OP_DIV, 1'b0);
        repeat ($urandom_range(1, 3)) next_cycle();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
